mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Shares one specialized-multiplier core between two requesters. Each accepted 4-bit operand is mapped as follows: 0–2 → x, 3–5 → 2x+1, 6–8 → 2x−1, anything else → error. The result goes back to the owning requester through a one-entry response buffer, and the most recent result is shown on a 7-segment display. The block sits between the lab's input sources (switch sampler and counter sequencer) and the HEX display.

## Interface
- `FAIR`, default 1: 1 = round-robin arbitration; 0 = fixed priority, req0 wins.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req0_valid` / `req1_valid` input 1: requester has an operand.
- `req0_op` / `req1_op` input 4: operand; must be held stable while valid.
- `req0_ready` / `req1_ready` output 1: request accepted this cycle when valid & ready.
- `rsp0_valid` / `rsp1_valid` output 1: response buffer full.
- `rsp0_ready` / `rsp1_ready` input 1: requester consumes the response.
- `rsp0_data` / `rsp1_data` output 7: result, 0–15, zero-extended.
- `rsp0_err` / `rsp1_err` output 1: operand was > 8.
- `busy` output 1: an operation is in flight (state EXEC).
- `HEX` output 7: active-low segments, bit order gfedcba.

## Operation
- FSM has two states.
  - IDLE: arbitrate.
  - EXEC: core evaluates the latched operand.
- Eligibility: requester i is eligible when `reqi_valid` = 1 and `rspi_valid` = 0 (registered value; no same-cycle bypass of a pop).
- `reqi_ready` = 1 only in IDLE, and only for the single winner among eligible requesters.
  - FAIR = 1: when both are eligible, the requester not granted last wins. `last_grant` resets to 1, so req0 wins first.
  - FAIR = 0: req0 wins whenever it is eligible.
- On handshake: latch op and id into op_q / id_q, update `last_grant`, go IDLE → EXEC.
- In EXEC:
  - Write the core output to response buffer `id_q` and set `rspi_valid` = 1.
  - Update `HEX`.
  - Return to IDLE.
- Core arithmetic is done at 5 bits, then zero-extended to 7. Results:
  - op 0–2 → op.
  - op 3 → 7, 4 → 9, 5 → 11.
  - op 6 → 11, 7 → 13, 8 → 15.
  - op 9–15 → data 0 with err = 1.
- Response buffer pops on `rspi_valid` & `rspi_ready`: `rspi_valid` clears next edge; data and err are held.
- A requester has at most one operation outstanding (in flight or buffered).
- Reset values: state IDLE, `busy` 0, `rsp*_valid` 0, `rsp*_data` 0, `rsp*_err` 0, `last_grant` 1, `HEX` 7'b1111111 (blank).
- Reset asserted mid-EXEC: the in-flight operation is dropped and no response is produced.
- `req_op` changing while valid without ready: no effect; the value is sampled only at handshake.

## Timing
- Handshake at edge N. `rspi_valid` and `rspi_data` are visible after edge N+1; `HEX` is updated at the same edge.
- Peak throughput: one operation per 2 cycles.
- `reqi_ready` is combinational from valid, buffer state, FSM state and `last_grant`; there is no path from `req_op`.
- Earliest re-grant of a requester: a response popped at edge M allows a new handshake in cycle M+1.
- Simultaneous pop of rsp0 and grant of req1: both happen; the buffers are independent.

## Configuration
- `MULT_ARB_HEX_EN` defined:
  - `HEX` register present.
  - Results 0–15 shown as hex glyphs 0–F (e.g. 9 → 7'b0010000, 15 → 7'b0001110).
  - err shown as dash 7'b0111111.
- Not defined: no `HEX` register; `HEX` is tied to 7'b1111111.

## Structure
- Package `mult_arb_pkg` holds:
  - the state enum (IDLE, EXEC);
  - `OP_MAX` = 8;
  - the 16-entry active-low glyph constant array;
  - the `DASH` glyph constant.
- Sub-module `spec_mult_core`: purely combinational, op[3:0] → data[6:0], err. It is instantiated once and driven only from op_q.

## Test plan
- After reset, req0 op = 4 and `rsp0_ready` = 1 → `req0_ready` = 1 in cycle 0; `rsp0_valid` = 1 with data 9 and err 0 after edge 1; `HEX` = 7'b0010000.
- FAIR = 1, both requesters valid continuously (op0 = 2, op1 = 7), `rsp_ready` = 1 → grants alternate 0, 1, 0, 1 every 2 cycles; responses are 2 and 13.
- req1 op = 9 → `rsp1_data` = 0, `rsp1_err` = 1, `HEX` = 7'b0111111 (macro on) or 7'b1111111 (macro off).
- `rsp0_ready` held low, req0 and req1 continuously valid:
  - after the first req0 response, `req0_ready` stays 0 while req1 keeps being served;
  - raising `rsp0_ready` for one cycle pops the buffer, and req0 is granted the next cycle.
- FAIR = 0, both valid, both ready → req0 granted on every IDLE cycle; req1 is never granted while req0 stays eligible.
- Drop `rst_n` during EXEC → all outputs at reset values immediately; no response appears after release.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared types and constants for the multiplier arbiter.
//   state_t : arbiter FSM states (IDLE arbitrates, EXEC evaluates op_q)
//   OP_MAX  : largest operand the core maps; anything above is an error
//   GLYPH   : active-low 7-segment glyphs 0..F, bit order gfedcba
//   DASH    : glyph shown for an error result
//   BLANK   : all segments off
package mult_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  localparam logic [3:0] OP_MAX = 4'd8;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, // 0
    7'b1111001, // 1
    7'b0100100, // 2
    7'b0110000, // 3
    7'b0011001, // 4
    7'b0010010, // 5
    7'b0000010, // 6
    7'b1111000, // 7
    7'b0000000, // 8
    7'b0010000, // 9
    7'b0001000, // A
    7'b0000011, // b
    7'b1000110, // C
    7'b0100001, // d
    7'b0000110, // E
    7'b0001110  // F
  };

  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

endpackage

// File: rtl/spec_mult_core.sv
// spec_mult_core: combinational specialised multiplier.
//   op   [3:0] in  : operand
//   data [6:0] out : 0-2 -> op, 3-5 -> 2op+1, 6-8 -> 2op-1, else 0
//   err        out : operand above OP_MAX
// Arithmetic is carried at 5 bits (max result 15) and zero-extended.
module spec_mult_core
  import mult_arb_pkg::*;
(
  input  logic [3:0] op,
  output logic [6:0] data,
  output logic       err
);

  logic [4:0] op5;
  logic [4:0] res5;

  always_comb begin
    op5  = {1'b0, op};
    res5 = 5'd0;
    err  = 1'b0;
    if (op > OP_MAX) begin
      err = 1'b1;
    end else if (op <= 4'd2) begin
      res5 = op5;
    end else if (op <= 4'd5) begin
      res5 = {op5[3:0], 1'b0} + 5'd1;
    end else begin
      res5 = {op5[3:0], 1'b0} - 5'd1;
    end
  end

  assign data = {2'b00, res5};

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one spec_mult_core between two requesters.
//   FAIR            : 1 = round-robin, 0 = fixed priority (req0 wins)
//   clk, rst_n      : clock, asynchronous active-low reset
//   reqN_valid/op   : operand offer, held stable while valid
//   reqN_ready      : accept strobe (combinational, IDLE only)
//   rspN_valid/data/err, rspN_ready : one-entry response buffer per requester
//   busy            : operation in flight (EXEC)
//   HEX             : active-low gfedcba glyph of the latest result
// Optional feature macro: MULT_ARB_HEX_EN enables the HEX register; when
// undefined, HEX is tied blank.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_op,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_op,
  output logic       req1_ready,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [6:0] rsp0_data,
  output logic       rsp0_err,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [6:0] rsp1_data,
  output logic       rsp1_err,
  output logic       busy,
  output logic [6:0] HEX
);

  state_t     state_reg;
  state_t     state_next;
  logic [3:0] op_q;
  logic       id_q;
  logic       last_grant;   // 1 = req1 was granted last, so req0 wins a tie
  logic       elig0;
  logic       elig1;
  logic       gnt0;
  logic       gnt1;
  logic [6:0] core_data;
  logic       core_err;

  logic [1:0] rsp_valid_reg;
  logic [1:0] rsp_err_reg;
  logic [6:0] rsp_data_reg [2];
  logic [1:0] rsp_ready_w;

  // A requester with a full buffer (registered) is not eligible; a pop in
  // the same cycle does not bypass into eligibility.
  assign elig0 = req0_valid & ~rsp_valid_reg[0];
  assign elig1 = req1_valid & ~rsp_valid_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (elig0 && elig1) begin
          if (FAIR) begin
            gnt0 = last_grant;
            gnt1 = ~last_grant;
          end else begin
            gnt0 = 1'b1;
          end
        end else begin
          gnt0 = elig0;
          gnt1 = elig1;
        end
        if (gnt0 || gnt1) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign busy       = (state_reg == EXEC);

  // Operand and owner are captured only at handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= 4'd0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
    end else if (gnt0 || gnt1) begin
      op_q       <= gnt1 ? req1_op : req0_op;
      id_q       <= gnt1;
      last_grant <= gnt1;
    end
  end

  spec_mult_core u_core (
    .op   (op_q),
    .data (core_data),
    .err  (core_err)
  );

  assign rsp_ready_w = {rsp1_ready, rsp0_ready};

  // The owner's buffer is always empty during EXEC (no grant while full),
  // so the write never collides with a pop of the same buffer.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rsp_valid_reg[gi] <= 1'b0;
          rsp_data_reg[gi]  <= 7'd0;
          rsp_err_reg[gi]   <= 1'b0;
        end else if (state_reg == EXEC && id_q == (gi != 0)) begin
          rsp_valid_reg[gi] <= 1'b1;
          rsp_data_reg[gi]  <= core_data;
          rsp_err_reg[gi]   <= core_err;
        end else if (rsp_valid_reg[gi] && rsp_ready_w[gi]) begin
          rsp_valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign rsp0_valid = rsp_valid_reg[0];
  assign rsp0_data  = rsp_data_reg[0];
  assign rsp0_err   = rsp_err_reg[0];
  assign rsp1_valid = rsp_valid_reg[1];
  assign rsp1_data  = rsp_data_reg[1];
  assign rsp1_err   = rsp_err_reg[1];

`ifdef MULT_ARB_HEX_EN
  logic [6:0] hex_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_reg <= BLANK;
    end else if (state_reg == EXEC) begin
      hex_reg <= core_err ? DASH : GLYPH[core_data[3:0]];
    end
  end

  assign HEX = hex_reg;
`else
  assign HEX = BLANK;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: table-driven single-operation vectors plus hand-written
// multi-cycle sequences (alternation, fairness vs fixed priority,
// backpressure, reset during EXEC). dut_f uses FAIR=1, dut_p uses FAIR=0;
// both share all inputs.
module tb_mult_arbiter;

`ifdef MULT_ARB_HEX_EN
  localparam bit HEX_ON = 1'b1;
`else
  localparam bit HEX_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0] req0_op = 4'd0, req1_op = 4'd0;
  logic       rsp0_ready = 1'b0, rsp1_ready = 1'b0;

  logic       req0_ready_f, req1_ready_f, rsp0_valid_f, rsp1_valid_f;
  logic [6:0] rsp0_data_f, rsp1_data_f, hex_f;
  logic       rsp0_err_f, rsp1_err_f, busy_f;

  logic       req0_ready_p, req1_ready_p, rsp0_valid_p, rsp1_valid_p;
  logic [6:0] rsp0_data_p, rsp1_data_p, hex_p;
  logic       rsp0_err_p, rsp1_err_p, busy_p;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_arbiter #(.FAIR(1'b1)) dut_f (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_ready(req0_ready_f),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_ready(req1_ready_f),
    .rsp0_valid(rsp0_valid_f), .rsp0_ready(rsp0_ready),
    .rsp0_data(rsp0_data_f), .rsp0_err(rsp0_err_f),
    .rsp1_valid(rsp1_valid_f), .rsp1_ready(rsp1_ready),
    .rsp1_data(rsp1_data_f), .rsp1_err(rsp1_err_f),
    .busy(busy_f), .HEX(hex_f)
  );

  mult_arbiter #(.FAIR(1'b0)) dut_p (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_ready(req0_ready_p),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_ready(req1_ready_p),
    .rsp0_valid(rsp0_valid_p), .rsp0_ready(rsp0_ready),
    .rsp0_data(rsp0_data_p), .rsp0_err(rsp0_err_p),
    .rsp1_valid(rsp1_valid_p), .rsp1_ready(rsp1_ready),
    .rsp1_data(rsp1_data_p), .rsp1_err(rsp1_err_p),
    .busy(busy_p), .HEX(hex_p)
  );

  typedef struct {
    logic       id;
    logic [3:0] op;
    logic [6:0] data;
    logic       err;
    logic [6:0] hex;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [6:0] hx(input logic [6:0] g);
    return HEX_ON ? g : 7'b1111111;
  endfunction

  function automatic vec_t mk(input logic id, input logic [3:0] op,
                              input logic [6:0] data, input logic err,
                              input logic [6:0] glyph);
    vec_t v;
    v.id = id; v.op = op; v.data = data; v.err = err; v.hex = hx(glyph);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1;

    vecs[0]  = mk(1'b0, 4'd4,  7'd9,  1'b0, 7'b0010000);
    vecs[1]  = mk(1'b1, 4'd9,  7'd0,  1'b1, 7'b0111111);
    vecs[2]  = mk(1'b1, 4'd0,  7'd0,  1'b0, 7'b1000000);
    vecs[3]  = mk(1'b0, 4'd2,  7'd2,  1'b0, 7'b0100100);
    vecs[4]  = mk(1'b1, 4'd3,  7'd7,  1'b0, 7'b1111000);
    vecs[5]  = mk(1'b0, 4'd5,  7'd11, 1'b0, 7'b0000011);
    vecs[6]  = mk(1'b1, 4'd6,  7'd11, 1'b0, 7'b0000011);
    vecs[7]  = mk(1'b0, 4'd7,  7'd13, 1'b0, 7'b0100001);
    vecs[8]  = mk(1'b1, 4'd8,  7'd15, 1'b0, 7'b0001110);
    vecs[9]  = mk(1'b0, 4'd15, 7'd0,  1'b1, 7'b0111111);
    vecs[10] = mk(1'b0, 4'd1,  7'd1,  1'b0, 7'b1111001);

    // Reset values while rst_n is held low.
    repeat (2) tick();
    chk("rst busy",  busy_f, 0);
    chk("rst rsp0v", rsp0_valid_f, 0);
    chk("rst rsp1v", rsp1_valid_f, 0);
    chk("rst rsp0d", rsp0_data_f, 0);
    chk("rst rsp0e", rsp0_err_f, 0);
    chk("rst hex",   hex_f, 7'b1111111);
    chk("rst rdy0",  req0_ready_f, 0);
    do_reset();

    // Table: one operation per vector, buffer then popped.
    for (int i = 0; i < 11; i++) begin
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      if (vecs[i].id) begin req1_valid = 1'b1; req1_op = vecs[i].op; end
      else            begin req0_valid = 1'b1; req0_op = vecs[i].op; end
      #1;
      chk($sformatf("v%0d ready", i),
          vecs[i].id ? req1_ready_f : req0_ready_f, 1);
      tick();
      // Operand is sampled only at handshake; disturb it afterwards.
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_op = 4'hA; req1_op = 4'hA;
      #1;
      chk($sformatf("v%0d busy", i), busy_f, 1);
      tick();
      chk($sformatf("v%0d rspv", i), vecs[i].id ? rsp1_valid_f : rsp0_valid_f, 1);
      chk($sformatf("v%0d data", i), vecs[i].id ? rsp1_data_f : rsp0_data_f, vecs[i].data);
      chk($sformatf("v%0d err", i),  vecs[i].id ? rsp1_err_f : rsp0_err_f, vecs[i].err);
      chk($sformatf("v%0d hex", i),  hex_f, vecs[i].hex);
      chk($sformatf("v%0d busy0", i), busy_f, 0);
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      chk($sformatf("v%0d pop", i), vecs[i].id ? rsp1_valid_f : rsp0_valid_f, 0);
      chk($sformatf("v%0d hold", i), vecs[i].id ? rsp1_data_f : rsp0_data_f, vecs[i].data);
      $display("vec %0d id=%0d op=%0d data=%0d err=%0d", i, vecs[i].id,
               vecs[i].op, vecs[i].data, vecs[i].err);
    end

    // FAIR=1 alternation with both requesters continuously valid.
    do_reset();
    req0_valid = 1'b1; req0_op = 4'd2;
    req1_valid = 1'b1; req1_op = 4'd7;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("alt%0d rdy0", k), req0_ready_f, (k % 2 == 0));
      chk($sformatf("alt%0d rdy1", k), req1_ready_f, (k % 2 == 1));
      tick();
      chk($sformatf("alt%0d busy", k), busy_f, 1);
      tick();
      if (k % 2 == 0) begin
        chk($sformatf("alt%0d r0v", k), rsp0_valid_f, 1);
        chk($sformatf("alt%0d r0d", k), rsp0_data_f, 2);
      end else begin
        chk($sformatf("alt%0d r1v", k), rsp1_valid_f, 1);
        chk($sformatf("alt%0d r1d", k), rsp1_data_f, 13);
      end
      $display("alt %0d done", k);
    end

    // Tie after req0 was granted last: FAIR=1 picks req1, FAIR=0 picks req0.
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 4'd1;
    #1;
    chk("tie pre f", req0_ready_f, 1);
    chk("tie pre p", req0_ready_p, 1);
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    req0_valid = 1'b1; req0_op = 4'd2;
    req1_valid = 1'b1; req1_op = 4'd7;
    #1;
    chk("tie f rdy1", req1_ready_f, 1);
    chk("tie f rdy0", req0_ready_f, 0);
    chk("tie p rdy0", req0_ready_p, 1);
    chk("tie p rdy1", req1_ready_p, 0);
    $display("tie done");

    // Backpressure on rsp0: req1 keeps being served, req0 blocked.
    do_reset();
    req0_valid = 1'b1; req0_op = 4'd3;
    req1_valid = 1'b1; req1_op = 4'd5;
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    #1;
    chk("bp c0 rdy0", req0_ready_f, 1);
    tick();
    tick();
    chk("bp r0v", rsp0_valid_f, 1);
    chk("bp r0d", rsp0_data_f, 7);
    n1 = 0;
    for (int c = 2; c < 10; c++) begin
      chk($sformatf("bp c%0d rdy0", c), req0_ready_f, 0);
      if (req1_ready_f) n1++;
      if (c == 4) begin
        chk("bp r1v", rsp1_valid_f, 1);
        chk("bp r1d", rsp1_data_f, 11);
      end
      tick();
    end
    chk("bp grants1", n1, 3);
    chk("bp c10 rdy0", req0_ready_f, 0);
    chk("bp c10 rdy1", req1_ready_f, 0);
    rsp0_ready = 1'b1;
    req0_op = 4'd8;
    tick();
    rsp0_ready = 1'b0;
    #1;
    chk("bp c11 r0v", rsp0_valid_f, 0);
    chk("bp c11 rdy0", req0_ready_f, 1);
    chk("bp c11 rdy1", req1_ready_f, 0);
    tick();
    tick();
    chk("bp c13 r0v", rsp0_valid_f, 1);
    chk("bp c13 r0d", rsp0_data_f, 15);
    $display("backpressure done grants1=%0d", n1);

    // Reset during EXEC (req1 in flight): immediate reset values, no response.
    tick();
    chk("rx busy", busy_f, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rx busy0", busy_f, 0);
    chk("rx r0v", rsp0_valid_f, 0);
    chk("rx r0d", rsp0_data_f, 0);
    chk("rx r1v", rsp1_valid_f, 0);
    chk("rx r1d", rsp1_data_f, 0);
    chk("rx hex", hex_f, 7'b1111111);
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("rx post%0d r1v", j), rsp1_valid_f, 0);
      chk($sformatf("rx post%0d busy", j), busy_f, 0);
    end
    $display("reset-in-exec done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
